// File: rtl/ps2_pkg.sv
// Shared constants, frame state encoding and frame check for the PS/2 scan-code receiver.
package ps2_pkg;

   localparam logic [7:0]  PS2_EXT   = 8'hE0;
   localparam logic [7:0]  PS2_BRK   = 8'hF0;
   localparam int unsigned FRAME_LEN = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } frame_state_e;

   // Frame is {stop, parity, data[7:0], start}; data plus parity must have odd weight.
   function automatic logic frame_ok(input logic [10:0] f);
      return ~f[0] & f[10] & (^f[9:1]);
   endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer plus saturating deglitch filter for one PS/2 line; also reports 1->0 transitions.
module ps2_filter
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk25,
   input  logic clr,
   input  logic pin,
   output logic level,
   output logic fall
);

   localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [1:0]    sync_q,  sync_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          level_q, level_d;
   logic          fall_q,  fall_d;

   always_comb begin
      sync_d  = {sync_q[0], pin};
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      fall_d = level_q & ~level_d;
   end

   always_ff @(posedge clk25) begin
      if (clr) begin
         sync_q  <= '1;
         cnt_q   <= '0;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign fall  = fall_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets, tracks E0/F0 prefixes, emits make/break events.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic        clk25,
   input  logic        clr,
   input  logic        PS2C,
   input  logic        PS2D,
   output logic [15:0] key,
   output logic [7:0]  scan,
   output logic        ext,
   output logic        make,
   output logic        brk,
   output logic        frame_err
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [3:0]    CNT_FULL = 4'(FRAME_LEN);
   localparam logic [3:0]    CNT_LAST = 4'(FRAME_LEN - 1);

   logic c_lvl, c_fall, d_lvl, d_fall_unused;

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk25 (clk25),
      .clr   (clr),
      .pin   (PS2C),
      .level (c_lvl),
      .fall  (c_fall)
   );

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
      .clk25 (clk25),
      .clr   (clr),
      .pin   (PS2D),
      .level (d_lvl),
      .fall  (d_fall_unused)
   );

   frame_state_e  state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [10:0]   sh_q, sh_d;
   logic          ext_pend_q, ext_pend_d;
   logic          brk_pend_q, brk_pend_d;
   logic [15:0]   key_q, key_d;
   logic [7:0]    scan_q, scan_d;
   logic          ext_q, ext_d;
   logic          make_q, make_d;
   logic          brk_q, brk_d;
   logic          err_q, err_d;
   logic [7:0]    rx_byte;
   logic          c_lvl_unused;

   assign rx_byte      = sh_q[8:1];
   assign c_lvl_unused = c_lvl;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      sh_d       = sh_q;
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      key_d      = key_q;
      scan_d     = scan_q;
      ext_d      = ext_q;
      make_d     = 1'b0;
      brk_d      = 1'b0;
      err_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (c_fall) begin
               sh_d    = {d_lvl, sh_q[10:1]};
               cnt_d   = 4'd1;
               state_d = RECV;
            end
         end

         RECV: begin
            if (c_fall) begin
               sh_d  = {d_lvl, sh_q[10:1]};
               tmo_d = '0;
               if (cnt_q >= CNT_LAST) begin
                  cnt_d   = CNT_FULL;
                  state_d = CHECK;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else if (tmo_q == TMO_LAST) begin
               // Abandoned frame: prefix flags deliberately survive a timeout.
               state_d = IDLE;
               cnt_d   = '0;
               tmo_d   = '0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         CHECK: begin
            state_d    = IDLE;
            cnt_d      = '0;
            tmo_d      = '0;
            if (frame_ok(sh_q)) begin
               key_d = {key_q[7:0], rx_byte};
               if (rx_byte == PS2_EXT) begin
                  ext_pend_d = 1'b1;
               end else if (rx_byte == PS2_BRK) begin
                  brk_pend_d = 1'b1;
               end else begin
                  scan_d     = rx_byte;
                  ext_d      = ext_pend_q;
                  brk_d      = brk_pend_q;
                  make_d     = ~brk_pend_q;
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
               end
            end else begin
               err_d      = 1'b1;
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk25) begin
      if (clr) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tmo_q      <= '0;
         sh_q       <= '0;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         key_q      <= '0;
         scan_q     <= '0;
         ext_q      <= 1'b0;
         make_q     <= 1'b0;
         brk_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         sh_q       <= sh_d;
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         key_q      <= key_d;
         scan_q     <= scan_d;
         ext_q      <= ext_d;
         make_q     <= make_d;
         brk_q      <= brk_d;
         err_q      <= err_d;
      end
   end

   assign key       = key_q;
   assign scan      = scan_q;
   assign ext       = ext_q;
   assign make      = make_q;
   assign brk       = brk_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: serialises PS/2 frames on the pins and checks events and key history.
module tb_ps2_scan_rx;
   import ps2_pkg::*;

   localparam int unsigned HALF = 50;
   localparam int unsigned TMO  = 1000;

   logic        clk25 = 1'b0;
   logic        clr   = 1'b1;
   logic        PS2C  = 1'b1;
   logic        PS2D  = 1'b1;
   logic [15:0] key;
   logic [7:0]  scan;
   logic        ext, make, brk, frame_err;

   always #20 clk25 = ~clk25;

   ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT(TMO)) dut (
      .clk25     (clk25),
      .clr       (clr),
      .PS2C      (PS2C),
      .PS2D      (PS2D),
      .key       (key),
      .scan      (scan),
      .ext       (ext),
      .make      (make),
      .brk       (brk),
      .frame_err (frame_err)
   );

   int total = 0, bad = 0;
   int n_make = 0, n_brk = 0, n_err = 0, n_excl = 0, n_strobe = 0;
   int m0, b0, e0, s0;

   always @(negedge clk25) begin
      if (make)      n_make++;
      if (brk)       n_brk++;
      if (frame_err) n_err++;
      if (dut.c_fall) n_strobe++;
      if ((int'(make) + int'(brk) + int'(frame_err)) > 1) n_excl++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk25);
   endtask

   task automatic snap();
      m0 = n_make; b0 = n_brk; e0 = n_err; s0 = n_strobe;
   endtask

   task automatic send_bit(input logic b);
      PS2D = b;
      cyc(HALF);
      PS2C = 1'b0;
      cyc(HALF);
      PS2C = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip);
      logic p;
      p = ~(^b) ^ flip;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(1'b1);
      cyc(60);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      cyc(1);
   endtask

   initial begin
      cyc(5);
      clr = 1'b0;
      cyc(2);
      check("rst_key",   32'(key), 32'h0000);
      check("rst_scan",  32'(scan), 32'h00);
      check("rst_ext",   32'(ext), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));

      snap();
      send_frame(8'h1C, 1'b0);
      check("mk_key",  32'(key), 32'h001C);
      check("mk_scan", 32'(scan), 32'h1C);
      check("mk_ext",  32'(ext), 32'd0);
      check("mk_make", 32'(n_make - m0), 32'd1);
      check("mk_brk",  32'(n_brk - b0), 32'd0);

      snap();
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check("bk_key",  32'(key), 32'hF01C);
      check("bk_scan", 32'(scan), 32'h1C);
      check("bk_brk",  32'(n_brk - b0), 32'd1);
      check("bk_make", 32'(n_make - m0), 32'd0);

      snap();
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check("ebk_key",  32'(key), 32'hF075);
      check("ebk_ext",  32'(ext), 32'd1);
      check("ebk_brk",  32'(n_brk - b0), 32'd1);
      check("ebk_make", 32'(n_make - m0), 32'd0);
      snap();
      send_frame(8'h75, 1'b0);
      check("pl_make", 32'(n_make - m0), 32'd1);
      check("pl_ext",  32'(ext), 32'd0);
      check("pl_key",  32'(key), 32'h7575);

      do_clr();
      snap();
      send_frame(8'h1C, 1'b1);
      check("par_err",  32'(n_err - e0), 32'd1);
      check("par_key",  32'(key), 32'h0000);
      check("par_make", 32'(n_make - m0), 32'd0);
      snap();
      send_frame(8'h1B, 1'b0);
      check("p2_make", 32'(n_make - m0), 32'd1);
      check("p2_key",  32'(key), 32'h001B);
      check("p2_err",  32'(n_err - e0), 32'd0);

      snap();
      for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
      cyc(500);
      check("to_early", 32'(n_err - e0), 32'd0);
      check("to_recv",  32'(dut.state_q), 32'(RECV));
      cyc(700);
      check("to_err",   32'(n_err - e0), 32'd1);
      check("to_idle",  32'(dut.state_q), 32'(IDLE));
      snap();
      send_frame(8'h1C, 1'b0);
      check("to_make", 32'(n_make - m0), 32'd1);
      check("to_key",  32'(key), 32'h1B1C);

      snap();
      PS2C = 1'b0;
      cyc(4);
      PS2C = 1'b1;
      cyc(30);
      check("gl_strobe", 32'(n_strobe - s0), 32'd0);
      check("gl_idle",   32'(dut.state_q), 32'(IDLE));

      snap();
      for (int i = 0; i < 6; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
      cyc(20);
      do_clr();
      check("cl_key",   32'(key), 32'h0000);
      check("cl_scan",  32'(scan), 32'h00);
      check("cl_ext",   32'(ext), 32'd0);
      check("cl_state", 32'(dut.state_q), 32'(IDLE));
      cyc(20);
      check("cl_pulse", 32'((n_make - m0) + (n_brk - b0) + (n_err - e0)), 32'd0);
      snap();
      send_frame(8'h1C, 1'b0);
      check("cl_make", 32'(n_make - m0), 32'd1);
      check("cl_key2", 32'(key), 32'h001C);

      check("excl", 32'(n_excl), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

PS/2 keyboard receiver for the minicube design. It deglitches PS2C and PS2D, frames 11-bit PS/2 packets, and checks start, parity and stop bits. It tracks the E0 (extended) and F0 (break) prefixes and emits one make or break event per completed key code. It sits between the keyboard pins and the move-input logic, and drives the 16-bit `key` history used for LED display and move decoding.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical samples needed before the filtered PS2C/PS2D level changes.
- `TIMEOUT`, default 50000: clk25 cycles (2 ms) allowed between falling clock edges inside a frame before the frame is abandoned.

Ports:
- `clk25` in 1: 25 MHz system clock. Single clock domain.
- `clr` in 1: reset, synchronous, active-high.
- `PS2C` in 1: raw PS/2 clock, asynchronous.
- `PS2D` in 1: raw PS/2 data, asynchronous.
- `key` out 16: last two accepted bytes, `{previous, latest}`.
- `scan` out 8: final code byte of the most recent event, prefixes excluded.
- `ext` out 1: the most recent event carried an E0 prefix.
- `make` out 1: one-cycle pulse, key press event.
- `brk` out 1: one-cycle pulse, key release event.
- `frame_err` out 1: one-cycle pulse, bad start, parity or stop bit, or timeout.

## Operation
- Input conditioning: PS2C and PS2D each pass through a 2-FF synchronizer, then a `FILTER_LEN` saturating filter. The filtered level flips only after `FILTER_LEN` consecutive samples at the opposite value.
- Falling-edge strobe: asserted for one cycle when filtered PS2C goes 1→0. Filtered PS2D is sampled on the strobe.
- Frame FSM, states IDLE, RECV, CHECK:
  - IDLE→RECV on a strobe. This captures the start bit; bit count = 1.
  - In RECV, each strobe shifts the data bit into an 11-bit register, LSB first, and increments the count. At count 11 go to CHECK.
  - CHECK always lasts one cycle, then returns to IDLE.
  - A frame is valid when start=0, stop=1, and data plus parity has odd total parity.
- Timeout: a counter resets on every strobe and counts while in RECV. Reaching `TIMEOUT`-1 aborts the frame: return to IDLE, pulse `frame_err`, leave the prefix flags unchanged.
- Valid byte handling in CHECK, byte b:
  - `key` <= {key[7:0], b} for every valid byte, prefixes included.
  - b=E0: set `ext_pend`, no event.
  - b=F0: set `brk_pend`, no event.
  - Any other b:
    - `scan`<=b and `ext`<=ext_pend.
    - Pulse `brk` if brk_pend is set, else pulse `make`.
    - Clear both pending flags.
- Invalid byte: pulse `frame_err`, clear both pending flags, leave `key`/`scan`/`ext` unchanged.
- Typematic repeats are not suppressed; each repeated make code gives one `make` pulse.

## Timing
- Reset values:
  - `key`=16'h0000, `scan`=8'h00.
  - `ext`=0, `make`=0, `brk`=0, `frame_err`=0.
  - FSM=IDLE, pending flags=0, counters=0.
  - Filtered levels reset to 1 (bus idle high).
- Latency from a PS2C pin fall to the strobe is 2 synchronizer cycles + `FILTER_LEN` cycles + 1.
- Event outputs and `key`/`scan`/`ext` update together on the cycle after CHECK and are registered. Pulses last exactly one cycle.
- `make`, `brk` and `frame_err` are mutually exclusive in any cycle.
- A strobe arriving during CHECK is impossible: the host bit period is at least 60 µs, far longer than one cycle. If it occurs it is ignored.
- `clr` asserted mid-frame: the next cycle returns to the full reset state, the partial frame is discarded, and no pulse is emitted.
- Bit-count wrap is impossible: the count saturates at 11 and CHECK is forced.

## Structure
- Shared package `ps2_pkg`:
  - Constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0.
  - State encoding IDLE/RECV/CHECK.
  - Frame length 11.
- Sub-module `ps2_filter`: synchronizer plus saturating filter, instantiated twice (clock and data). It outputs the filtered level and, for the clock line, the fall strobe.
- Top body: frame FSM, timeout counter, prefix/event logic.

## Test plan
- Frame 0x1C (parity 0) at 12 kHz bus rate → `key`=16'h001C, `scan`=8'h1C, one `make`, `ext`=0.
- Frames F0, 1C → `key`=16'hF01C, one `brk`, no `make`, `scan`=8'h1C.
- Frames E0, F0, 75 → `key`=16'hF075, `ext`=1, one `brk`. A following plain 75 → `make` with `ext`=0.
- Frame 0x1C with parity bit flipped → one `frame_err`, `key` unchanged. A later valid 0x1B → `make`, `key`=16'h001B.
- Stop after 5 clock edges, idle 2.1 ms → one `frame_err` at `TIMEOUT`, FSM=IDLE. The next full frame decodes correctly.
- 4-cycle low glitch on PS2C → no strobe, FSM stays IDLE. `clr` pulse mid-frame → all outputs at reset values, no pulse.
